rate_timer: RTL

RATE_TIMER -- requirements
Module: rate_timer

---
 rtl/rate_timer_pkg.sv | 36 +++
 rtl/rate_timer_core.sv | 49 ++++
 rtl/rate_timer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/rate_timer_pkg.sv
// rate_timer_pkg -- shared types and helpers for the rate_timer block.
//
// Contents:
//   state_t      : FSM state encoding (IDLE, RUN and, with burst support, DONE)
//   calc_period  : period in clock cycles for a given speed code
//
// Configuration macro: RATE_TIMER_BURST_EN adds the DONE state used by
// finite-length bursts.

package rate_timer_pkg;

`ifdef RATE_TIMER_BURST_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
`else
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;
`endif

  // Cycles per output pulse at speed code 'speed'. Each speed step doubles
  // the rate. Never returns less than 2, so the terminal count can never
  // coincide with the load that starts a period.
  function automatic int calc_period(input int clk_hz, input int base_hz,
                                     input int speed);
    int p;
    p = clk_hz / (base_hz << speed);
    if (p < 2) p = 2;
    return p;
  endfunction

endpackage

// File: rtl/rate_timer_core.sv
// rate_timer_core -- period down-counter with reload.
//
// Ports:
//   clk, rst_n   : clock, async active-low reset (already synchronised)
//   load         : load reload_m1 (start of a run)
//   advance      : counter is running this cycle
//   speed_change : speed changed this cycle, restart the period
//   reload_m1    : next period minus one
//   half_thresh  : half of the current period
//   at_tc        : counter is at its terminal count (0)
//   upper_half   : counter is still in the first half of its period
//
// RESET_M1 is the reset value of the counter (period at speed 0, minus one).

module rate_timer_core #(
  parameter int               CNT_W    = 4,
  parameter logic [CNT_W-1:0] RESET_M1 = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             advance,
  input  logic             speed_change,
  input  logic [CNT_W-1:0] reload_m1,
  input  logic [CNT_W-1:0] half_thresh,
  output logic             at_tc,
  output logic             upper_half
);

  logic [CNT_W-1:0] cnt_q;

  assign at_tc      = (cnt_q == '0);
  assign upper_half = (cnt_q >= half_thresh);

  // Counts down from P-1 to 0. A terminal count and a speed change both
  // restart the period from the new reload value; when they coincide the
  // caller still issues the pulse, so only one reload is needed here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RESET_M1;
    end else if (load) begin
      cnt_q <= reload_m1;
    end else if (advance) begin
      if (at_tc || speed_change) cnt_q <= reload_m1;
      else                       cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/rate_timer.sv
// rate_timer -- programmable-rate pulse generator with speed control.
//
// Ports:
//   clk, reset   : clock (rising edge), async active-low reset
//   start, stop  : begin a run / abort back to idle (stop wins)
//   load_speed   : load speed_i (clamped to MAX_SPEED)
//   speed_i      : requested speed code
//   speed_up     : raise speed by one, saturating (load_speed wins)
//   burst_len    : pulses per run, sampled on start, 0 = continuous
//   pulse        : one-cycle tick per period
//   half         : high in the first half of each period while running
//   busy         : high while running
//   done         : one-cycle strobe after the last pulse of a burst
//   speed_o      : current speed code
//   pulses_left  : pulses remaining in the current burst
//
// Configuration macro: RATE_TIMER_BURST_EN. When undefined, burst_len,
// pulses_left, done and the DONE state do not exist and a run continues
// until stop.

module rate_timer
  import rate_timer_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BASE_HZ   = 1,
  parameter int SPEED_W   = 3,
  parameter int MAX_SPEED = 4,
  parameter int BURST_W   = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               load_speed,
  input  logic [SPEED_W-1:0] speed_i,
  input  logic               speed_up,
`ifdef RATE_TIMER_BURST_EN
  input  logic [BURST_W-1:0] burst_len,
  output logic               done,
  output logic [BURST_W-1:0] pulses_left,
`endif
  output logic               pulse,
  output logic               half,
  output logic               busy,
  output logic [SPEED_W-1:0] speed_o
);

  localparam int CNT_W_RAW = $clog2(CLK_HZ / BASE_HZ);
  localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam logic [CNT_W-1:0]   RESET_M1 = CNT_W'(calc_period(CLK_HZ, BASE_HZ, 0) - 1);
  localparam logic [SPEED_W-1:0] MAX_CODE = SPEED_W'(MAX_SPEED);

  logic [1:0]         rst_sync;
  logic               rst_n;
  state_t             state_q, state_next;
  logic [SPEED_W-1:0] speed_q, speed_next;
  logic               speed_change;
  logic               running, stay_running, load;
  logic [CNT_W-1:0]   reload_m1, half_thresh;
  logic               at_tc, upper_half, fire;
  logic               pulse_q, half_q;

  // Reset asserts everything immediately but is released only after two
  // clock edges, so the first start can never race the reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

`ifdef RATE_TIMER_BURST_EN
  logic [BURST_W-1:0] left_q;
  logic               burst_mode_q;
  logic               burst_end;

  // The registered pulse that took the count to zero ends the burst.
  assign burst_end = pulse_q && burst_mode_q && (left_q == '0);
`endif

  // Next-state logic. Stop overrides everything; start is only looked at in
  // IDLE, so a start during a run is ignored.
  always_comb begin
    state_next = state_q;
    if (stop) begin
      state_next = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) state_next = RUN;
        RUN: begin
`ifdef RATE_TIMER_BURST_EN
          if (burst_end) state_next = DONE;
`endif
        end
`ifdef RATE_TIMER_BURST_EN
        DONE: state_next = IDLE;
`endif
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_next;
  end

  // Speed selection: load_speed clamps to the highest legal code and takes
  // precedence over speed_up, which saturates. Speed survives stop/start.
  always_comb begin
    speed_next = speed_q;
    if (load_speed)
      speed_next = (speed_i > MAX_CODE) ? MAX_CODE : speed_i;
    else if (speed_up && (speed_q != MAX_CODE))
      speed_next = speed_q + SPEED_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) speed_q <= '0;
    else        speed_q <= speed_next;
  end

  assign speed_change = load_speed || (speed_next != speed_q);

  // Period lookup. Every calc_period call has a constant argument, so this
  // folds into a small mux rather than a divider.
  always_comb begin
    reload_m1   = RESET_M1;
    half_thresh = CNT_W'(calc_period(CLK_HZ, BASE_HZ, 0) / 2);
    for (int s = 0; s <= MAX_SPEED; s++) begin
      if (speed_next == SPEED_W'(s))
        reload_m1 = CNT_W'(calc_period(CLK_HZ, BASE_HZ, s) - 1);
      if (speed_q == SPEED_W'(s))
        half_thresh = CNT_W'(calc_period(CLK_HZ, BASE_HZ, s) / 2);
    end
  end

  assign running      = (state_q == RUN);
  assign stay_running = (state_next == RUN);
  assign load         = (state_q == IDLE) && stay_running;
  assign fire         = running && stay_running && at_tc;

  rate_timer_core #(
    .CNT_W    (CNT_W),
    .RESET_M1 (RESET_M1)
  ) u_core (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load),
    .advance      (running && stay_running),
    .speed_change (speed_change),
    .reload_m1    (reload_m1),
    .half_thresh  (half_thresh),
    .at_tc        (at_tc),
    .upper_half   (upper_half)
  );

  // Pulse and half are registered. half looks at the count before the edge,
  // i.e. the cycles remaining until the next pulse, and drops as soon as the
  // run is leaving RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_q <= 1'b0;
      half_q  <= 1'b0;
    end else begin
      pulse_q <= fire;
      half_q  <= running && stay_running && upper_half;
    end
  end

`ifdef RATE_TIMER_BURST_EN
  // Burst bookkeeping: length captured on start, decremented on each pulse
  // of a finite burst. A zero length marks a continuous run and stays 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_q       <= '0;
      burst_mode_q <= 1'b0;
    end else if (load) begin
      left_q       <= burst_len;
      burst_mode_q <= (burst_len != '0);
    end else if (fire && burst_mode_q && (left_q != '0)) begin
      left_q <= left_q - BURST_W'(1);
    end
  end

  assign done        = (state_q == DONE);
  assign pulses_left = left_q;
`endif

  assign pulse   = pulse_q;
  assign half    = half_q;
  assign busy    = running;
  assign speed_o = speed_q;

endmodule
